// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP constants, completer FSM states and first-BE decode helpers
// for the single-DW memory-read completer.
package pcileech_tlp_pkg;

    // {fmt[2:0], type[4:0]}
    localparam logic [7:0] MRD32 = 8'b000_00000;
    localparam logic [7:0] MRD64 = 8'b001_00000;
    localparam logic [7:0] CPL   = 8'b000_01010;
    localparam logic [7:0] CPLD  = 8'b010_01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_DRAIN,
        S_RD,
        S_WAIT,
        S_CPL0,
        S_CPL1
    } state_e;

    function automatic logic [11:0] be_to_bytecount(input logic [3:0] be);
        logic [11:0] bc;
        casez (be)
            4'b1??1:                     bc = 12'd4;
            4'b01?1, 4'b1?10:            bc = 12'd3;
            4'b0011, 4'b0110, 4'b1100:   bc = 12'd2;
            default:                     bc = 12'd1;
        endcase
        return bc;
    endfunction

    // Index of the lowest enabled byte; an all-zero BE reads as byte 0.
    function automatic logic [1:0] be_to_loaddr(input logic [3:0] be);
        logic [1:0] idx;
        if (be[0])      idx = 2'd0;
        else if (be[1]) idx = 2'd1;
        else if (be[2]) idx = 2'd2;
        else if (be[3]) idx = 2'd3;
        else            idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/pcileech_tlp_cpl_hdr.sv
// Combinational builder of the completion header DWs (CplD, or UR Cpl when ur=1)
// from the fields captured off the request.
module pcileech_tlp_cpl_hdr
    import pcileech_tlp_pkg::*;
(
    input  logic        ur,
    input  logic [2:0]  tc,
    input  logic [1:0]  attr,
    input  logic [15:0] completer_id,
    input  logic [15:0] requester_id,
    input  logic [7:0]  tag,
    input  logic [3:0]  first_be,
    input  logic [4:0]  addr_lo,
    output logic [31:0] dw0,
    output logic [31:0] dw1,
    output logic [31:0] dw2
);

    logic [7:0]  fmt_type;
    logic [2:0]  status;
    logic [9:0]  length;
    logic [11:0] byte_count;
    logic [6:0]  lower_addr;

    always_comb begin
        fmt_type   = ur ? CPL : CPLD;
        status     = ur ? CPL_UR : CPL_SC;
        length     = ur ? 10'd0 : 10'd1;
        byte_count = ur ? 12'd4 : be_to_bytecount(first_be);
        lower_addr = ur ? {addr_lo, 2'b00} : {addr_lo, be_to_loaddr(first_be)};

        dw0 = {fmt_type, 1'b0, tc, 6'b0, attr, 2'b0, length};
        dw1 = {completer_id, status, 1'b0, byte_count};
        dw2 = {requester_id, tag, 1'b0, lower_addr};
    end

endmodule

// File: rtl/pcileech_tlp_cpl_tx.sv
// Single-DW MRd32/MRd64 completer on the 64-bit AXI-S TLP interface.
// Define PCILEECH_CPL_UR_EN to answer MRd with length != 1 by an Unsupported Request Cpl.
module pcileech_tlp_cpl_tx
    import pcileech_tlp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk_pcie,
    input  logic              rst_n,
    input  logic [63:0]       rx_data,
    input  logic [7:0]        rx_keep,
    input  logic              rx_last,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [63:0]       tx_data,
    output logic [7:0]        tx_keep,
    output logic              tx_last,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [15:0]       cfg_completer_id,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [15:0]       stat_cpl_cnt
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_e              state_q, state_d;
    logic                ur_q, ur_d;
    logic                is64_q, is64_d;
    logic [2:0]          tc_q, tc_d;
    logic [1:0]          attr_q, attr_d;
    logic [15:0]         req_id_q, req_id_d;
    logic [7:0]          tag_q, tag_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          addr_lo_q, addr_lo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          lat_q, lat_d;
    logic [63:0]         tx_data_q, tx_data_d;
    logic [7:0]          tx_keep_q, tx_keep_d;
    logic                tx_last_q, tx_last_d;
    logic                tx_valid_q, tx_valid_d;
    logic [15:0]         cpl_cnt_q, cpl_cnt_d;

    logic                rx_accept;
    logic                is_mrd;
    logic                load_beat0;
    logic [31:0]         req_addr;
    logic [31:0]         hdr_dw0, hdr_dw1, hdr_dw2;
    logic                unused_rx;

    assign unused_rx = ^{rx_keep, rx_data};

    assign rx_ready     = (state_q == S_IDLE) || (state_q == S_HDR1) || (state_q == S_DRAIN);
    assign rx_accept    = rx_valid & rx_ready;
    assign is_mrd       = (rx_data[31:24] == MRD32) || (rx_data[31:24] == MRD64);
    assign req_addr     = is64_q ? rx_data[63:32] : rx_data[31:0];
    assign rd_en        = (state_q == S_RD);
    assign rd_addr      = addr_q;
    assign tx_data      = tx_data_q;
    assign tx_keep      = tx_keep_q;
    assign tx_last      = tx_last_q;
    assign tx_valid     = tx_valid_q;
    assign stat_cpl_cnt = cpl_cnt_q;

    pcileech_tlp_cpl_hdr u_hdr (
        .ur           (ur_q),
        .tc           (tc_q),
        .attr         (attr_q),
        .completer_id (cfg_completer_id),
        .requester_id (req_id_q),
        .tag          (tag_q),
        .first_be     (be_q),
        .addr_lo      (addr_lo_q),
        .dw0          (hdr_dw0),
        .dw1          (hdr_dw1),
        .dw2          (hdr_dw2)
    );

    always_comb begin
        state_d    = state_q;
        ur_d       = ur_q;
        is64_d     = is64_q;
        tc_d       = tc_q;
        attr_d     = attr_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        be_d       = be_q;
        addr_d     = addr_q;
        addr_lo_d  = addr_lo_q;
        rdata_d    = rdata_q;
        lat_d      = lat_q;
        tx_data_d  = tx_data_q;
        tx_keep_d  = tx_keep_q;
        tx_last_d  = tx_last_q;
        tx_valid_d = tx_valid_q;
        cpl_cnt_d  = cpl_cnt_q;
        load_beat0 = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_accept) begin
                    tc_d     = rx_data[22:20];
                    attr_d   = rx_data[13:12];
                    req_id_d = rx_data[63:48];
                    tag_d    = rx_data[47:40];
                    be_d     = rx_data[35:32];
                    is64_d   = rx_data[29];
                    ur_d     = 1'b0;
                    if (rx_last)
                        state_d = S_IDLE;
                    else if (is_mrd && rx_data[9:0] == 10'd1)
                        state_d = S_HDR1;
`ifdef PCILEECH_CPL_UR_EN
                    else if (is_mrd) begin
                        state_d = S_HDR1;
                        ur_d    = 1'b1;
                    end
`endif
                    else
                        state_d = S_DRAIN;
                end
            end
            S_HDR1: begin
                if (rx_accept) begin
                    addr_d    = req_addr[ADDR_W+1:2];
                    addr_lo_d = req_addr[6:2];
                    if (!rx_last)
                        state_d = S_DRAIN;
                    else if (ur_q)
                        load_beat0 = 1'b1;
                    else
                        state_d = S_RD;
                end
            end
            S_DRAIN: begin
                // A UR request still owes its Cpl once the TLP is fully consumed.
                if (rx_accept && rx_last) begin
                    if (ur_q)
                        load_beat0 = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            S_RD: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    rdata_d    = rd_data;
                    load_beat0 = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_CPL0: begin
                if (tx_ready) begin
                    tx_data_d = ur_q ? {32'h0, hdr_dw2} : {rdata_q, hdr_dw2};
                    tx_keep_d = ur_q ? 8'h0F : 8'hFF;
                    tx_last_d = 1'b1;
                    state_d   = S_CPL1;
                end
            end
            S_CPL1: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    cpl_cnt_d  = cpl_cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_beat0) begin
            tx_data_d  = {hdr_dw1, hdr_dw0};
            tx_keep_d  = 8'hFF;
            tx_last_d  = 1'b0;
            tx_valid_d = 1'b1;
            state_d    = S_CPL0;
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ur_q       <= 1'b0;
            is64_q     <= 1'b0;
            tc_q       <= '0;
            attr_q     <= '0;
            req_id_q   <= '0;
            tag_q      <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            addr_lo_q  <= '0;
            rdata_q    <= '0;
            lat_q      <= '0;
            tx_data_q  <= '0;
            tx_keep_q  <= '0;
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            cpl_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ur_q       <= ur_d;
            is64_q     <= is64_d;
            tc_q       <= tc_d;
            attr_q     <= attr_d;
            req_id_q   <= req_id_d;
            tag_q      <= tag_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            addr_lo_q  <= addr_lo_d;
            rdata_q    <= rdata_d;
            lat_q      <= lat_d;
            tx_data_q  <= tx_data_d;
            tx_keep_q  <= tx_keep_d;
            tx_last_q  <= tx_last_d;
            tx_valid_q <= tx_valid_d;
            cpl_cnt_q  <= cpl_cnt_d;
        end
    end

endmodule
